fetch_stage: RTL

Instruction-fetch stage downstream of the PC register. Takes the current `pc` value, issues a read to instruction memory over a valid/ready request channel, and delivers the returned word into the IF/ID pipeline register for decode. It also drives `pc_en` so the PC register advances only when a fetch is accepted. Decode stalls (`id_stall`) and branch/jump redirects (`flush`) are handled with a one-entry hold buffer and drop-tracking of in-flight reads.

---
 rtl/mips_pkg.sv | 16 +
 rtl/ifid_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load, hold on stall, invalidate on flush.
module ifid_reg
  import mips_pkg::*;
#(
  parameter int unsigned        ADDR_W = ADDR_W_DEF,
  parameter int unsigned        DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  NOP    = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              stall,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4
);

  // Flush beats load; an unstalled, unloaded register drains to invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP;
      pc    <= '0;
      pc4   <= ADDR_W'(4);
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
      pc4   <= load_pc + ADDR_W'(4);
    end else if (!stall) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read, one-entry hold buffer,
// and drop tracking so reads issued before a redirect are discarded.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned        ADDR_W = ADDR_W_DEF,
  parameter int unsigned        DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  NOP    = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              flush,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc4
);

  fetch_state_t      state, state_d;
  logic              drop, drop_d;
  logic [ADDR_W-1:0] req_pc, req_pc_d;
  logic [ADDR_W-1:0] hold_pc, hold_pc_d;
  logic [DATA_W-1:0] hold_instr, hold_instr_d;
  logic              ifid_load;
  logic [DATA_W-1:0] ifid_load_instr;
  logic [ADDR_W-1:0] ifid_load_pc;

  // Request channel is combinational from state and pc; held low in reset.
  assign imem_addr = pc & ~ADDR_W'(3);
  assign imem_req  = (state == REQ) && !rst;
  assign pc_en     = imem_req && imem_ready;

  // Next-state, drop tracking, hold buffer and IF/ID load selection.
  always_comb begin
    state_d         = state;
    drop_d          = drop;
    req_pc_d        = req_pc;
    hold_pc_d       = hold_pc;
    hold_instr_d    = hold_instr;
    ifid_load       = 1'b0;
    ifid_load_instr = imem_rdata;
    ifid_load_pc    = req_pc;
    case (state)
      REQ: begin
        if (pc_en) begin
          req_pc_d = imem_addr;
          state_d  = WAIT;
          if (flush) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          drop_d  = 1'b0;
          state_d = REQ;
          if (!flush && !drop) begin
            if (!ifid_valid || !id_stall) begin
              ifid_load = 1'b1;
            end else begin
              hold_instr_d = imem_rdata;
              hold_pc_d    = req_pc;
              state_d      = HOLD;
            end
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          hold_instr_d = '0;
          hold_pc_d    = '0;
          state_d      = REQ;
        end else if (!id_stall) begin
          ifid_load       = 1'b1;
          ifid_load_instr = hold_instr;
          ifid_load_pc    = hold_pc;
          state_d         = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // State, drop flag, request address and hold buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= REQ;
      drop       <= 1'b0;
      req_pc     <= '0;
      hold_pc    <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_d;
      drop       <= drop_d;
      req_pc     <= req_pc_d;
      hold_pc    <= hold_pc_d;
      hold_instr <= hold_instr_d;
    end
  end

  ifid_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NOP    (NOP)
  ) u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .load       (ifid_load),
    .stall      (id_stall),
    .load_instr (ifid_load_instr),
    .load_pc    (ifid_load_pc),
    .valid      (ifid_valid),
    .instr      (ifid_instr),
    .pc         (ifid_pc),
    .pc4        (ifid_pc4)
  );

endmodule
